hood_key_frontend: RTL

Input-conditioning stage for the range-hood controller. It sits directly upstream of the exhaust mode FSM. It synchronises and debounces the five raw push-buttons and runs the power on/off state machine that drives is_on. It emits single-cycle, mutually exclusive key pulses (menu/level1/level2/level3) and a 1 Hz tick for the countdown logic.

---
 rtl/hood_key_frontend.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/hood_key_frontend.sv
// Range-hood key front end: two-flop synchronisers, per-button debounce, power
// on/off state machine, gated single-cycle function-key pulses and a 1 Hz tick.
module hood_key_frontend #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int DEBOUNCE_MS  = 20,
  parameter int LONG_PRESS_S = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic power_btn_raw,
  input  logic menu_btn_raw,
  input  logic level1_btn_raw,
  input  logic level2_btn_raw,
  input  logic level3_btn_raw,
  output logic is_on,
  output logic menu_key,
  output logic level1_key,
  output logic level2_key,
  output logic level3_key,
  output logic tick_1hz,
  output logic power_hold
);
  localparam int DB_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int LP_CYCLES = CLK_FREQ * LONG_PRESS_S;
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam int LP_W = $clog2(LP_CYCLES + 1);
  localparam int TK_W = $clog2(CLK_FREQ + 1);
  localparam int NB   = 5;
  localparam int PWR  = 0;

  typedef enum logic [2:0] {
    S_OFF,
    S_ON_WAIT_REL,
    S_ON,
    S_HOLD,
    S_OFF_WAIT_REL
  } pwr_state_t;

  logic [NB-1:0]   raw;
  logic [NB-1:0]   sync1;
  logic [NB-1:0]   sync2;
  logic [NB-1:0]   stable;
  logic [NB-1:0]   stable_q;
  logic [NB-1:0]   press;
  logic [DB_W-1:0] db_cnt [NB];
  pwr_state_t      state;
  pwr_state_t      state_next;
  logic [LP_W-1:0] hold_cnt;
  logic [LP_W-1:0] hold_next;
  logic [3:0]      fkey_press;
  logic [3:0]      fkey_grant;
  logic [TK_W-1:0] tick_cnt;

  // Bit order: power, menu, level1, level2, level3.
  assign raw = {level3_btn_raw, level2_btn_raw, level1_btn_raw, menu_btn_raw, power_btn_raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after it differs from stable for DB_CYCLES+1 samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      stable_q <= stable;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_CYCLES)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = stable & ~stable_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_OFF;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    case (state)
      S_OFF:         if (press[PWR]) state_next = S_ON_WAIT_REL;
      S_ON_WAIT_REL: if (!stable[PWR]) state_next = S_ON;
      S_ON: begin
        if (press[PWR]) begin
          state_next = S_HOLD;
          hold_next  = '0;
        end
      end
      S_HOLD: begin
        // Release wins over the terminal count: a short press just returns to ON.
        hold_next = hold_cnt + LP_W'(1);
        if (!stable[PWR]) state_next = S_ON;
        else if (hold_next == LP_W'(LP_CYCLES)) state_next = S_OFF_WAIT_REL;
      end
      S_OFF_WAIT_REL: if (!stable[PWR]) state_next = S_OFF;
      default:        state_next = S_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_on      <= 1'b0;
      power_hold <= 1'b0;
    end else begin
      is_on      <= (state == S_ON_WAIT_REL) || (state == S_ON) || (state == S_HOLD);
      power_hold <= (state == S_HOLD);
    end
  end

  // Function keys: menu > level1 > level2 > level3; losers are dropped.
  assign fkey_press = press[4:1] & {4{is_on}};

  always_comb begin
    fkey_grant = '0;
    if (fkey_press[0])      fkey_grant[0] = 1'b1;
    else if (fkey_press[1]) fkey_grant[1] = 1'b1;
    else if (fkey_press[2]) fkey_grant[2] = 1'b1;
    else if (fkey_press[3]) fkey_grant[3] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      menu_key   <= 1'b0;
      level1_key <= 1'b0;
      level2_key <= 1'b0;
      level3_key <= 1'b0;
    end else begin
      menu_key   <= fkey_grant[0];
      level1_key <= fkey_grant[1];
      level2_key <= fkey_grant[2];
      level3_key <= fkey_grant[3];
    end
  end

  // Held at zero while off so the first tick lands CLK_FREQ cycles after power-on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      tick_1hz <= 1'b0;
    end else if (!is_on) begin
      tick_cnt <= '0;
      tick_1hz <= 1'b0;
    end else if (tick_cnt == TK_W'(CLK_FREQ - 1)) begin
      tick_cnt <= '0;
      tick_1hz <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + TK_W'(1);
      tick_1hz <= 1'b0;
    end
  end
endmodule
